// File: rtl/conv_tap_sequencer_pkg.sv
// Shared types and default sizing for the convolution tap sequencer.
package conv_tap_sequencer_pkg;

    localparam int DEF_NUM_TAPS    = 15;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_NUM_WINDOWS = 16;
    localparam int DEF_WIN_W       = 4;

    // Ring reset: only the top bit set, which encodes to tap address 0.
    localparam logic [DEF_NUM_TAPS-1:0] DEF_RING_RESET = 15'h4000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_OUTPUT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tap_ring_encoder.sv
// One-hot tap ring to binary tap address. The top ring bit maps to address 0,
// bit i maps to i+1; any non-one-hot ring gives all ones and flags o_invalid.
module tap_ring_encoder #(
    parameter int NUM_TAPS = 15,
    parameter int ADDR_W   = 4
) (
    input  logic [NUM_TAPS-1:0] i_ring,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_invalid
);

    logic [ADDR_W-1:0] w_idx;

    always_comb begin
        o_invalid = (i_ring == '0) || ((i_ring & (i_ring - NUM_TAPS'(1))) != '0);
        w_idx     = '0;
        for (int i = 0; i < NUM_TAPS - 1; i++) begin
            if (i_ring[i]) begin
                w_idx = ADDR_W'(i + 1);
            end
        end
        o_addr = o_invalid ? '1 : w_idx;
    end

endmodule

// File: rtl/conv_tap_sequencer.sv
// Sequences one CNN convolution pass: clear, NUM_TAPS MAC taps, hand-off per window.
// Optional one-hot ring check with sticky ring_err: define TAP_RING_CHECK_EN.
module conv_tap_sequencer
    import conv_tap_sequencer_pkg::*;
#(
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_WINDOWS = DEF_NUM_WINDOWS,
    parameter int WIN_W       = DEF_WIN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mac_ready,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                acc_clear,
    output logic                mac_en,
    output logic [NUM_TAPS-1:0] ring_out,
    output logic [ADDR_W-1:0]   tap_addr,
    output logic [WIN_W-1:0]    window_idx,
    output logic                out_valid
`ifdef TAP_RING_CHECK_EN
    ,
    output logic                ring_err
`endif
);

    localparam logic [NUM_TAPS-1:0] LP_RING_RST = {1'b1, {(NUM_TAPS-1){1'b0}}};

    // Handshake: out_valid is held in OUTPUT until a cycle with out_ready=1;
    // that cycle is the transfer, and the window result is consumed on it.

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_TAPS-1:0] r_ring;
    logic [NUM_TAPS-1:0] w_ring_nxt;
    logic [WIN_W-1:0]    r_win_idx;
    logic [WIN_W-1:0]    w_win_nxt;
    logic [ADDR_W-1:0]   w_tap_addr;
    logic                w_ring_invalid;
    logic                w_halt;

    tap_ring_encoder #(
        .NUM_TAPS (NUM_TAPS),
        .ADDR_W   (ADDR_W)
    ) u_tap_ring_encoder (
        .i_ring    (r_ring),
        .o_addr    (w_tap_addr),
        .o_invalid (w_ring_invalid)
    );

`ifdef TAP_RING_CHECK_EN
    logic r_ring_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ring_err <= 1'b0;
        end else if (w_ring_invalid) begin
            r_ring_err <= 1'b1;
        end
    end

    // Halt already in the offending cycle so no tap is issued from a bad ring.
    assign w_halt   = r_ring_err | w_ring_invalid;
    assign ring_err = r_ring_err;
`else
    logic w_unused_invalid;
    assign w_unused_invalid = w_ring_invalid;
    assign w_halt           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ring    <= LP_RING_RST;
            r_win_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ring    <= w_ring_nxt;
            r_win_idx <= w_win_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring;
        w_win_nxt   = r_win_idx;
        busy        = (r_state != ST_IDLE);
        done        = 1'b0;
        acc_clear   = 1'b0;
        mac_en      = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_clear   = 1'b1;
                w_ring_nxt  = LP_RING_RST;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A stalled cycle holds the ring, so no tap is skipped or repeated.
                mac_en = mac_ready;
                if (mac_ready) begin
                    w_ring_nxt = {r_ring[NUM_TAPS-2:0], r_ring[NUM_TAPS-1]};
                    if (w_tap_addr == ADDR_W'(NUM_TAPS - 1)) begin
                        w_state_nxt = ST_OUTPUT;
                    end
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_win_idx == WIN_W'(NUM_WINDOWS - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_win_nxt   = r_win_idx + WIN_W'(1);
                        w_state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_win_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_halt) begin
            w_state_nxt = ST_IDLE;
            mac_en      = 1'b0;
        end
    end

    assign ring_out   = r_ring;
    assign tap_addr   = w_tap_addr;
    assign window_idx = r_win_idx;

endmodule

// File: doc/conv_tap_sequencer.md
Name: conv_tap_sequencer

Overview:
Sequences one single-layer CNN convolution pass. It owns a one-hot tap ring counter and encodes the ring into a binary tap address for the weight/pixel buffers. It drives MAC enable and accumulator clear for each window, and hands finished window results downstream with a valid/ready handshake. It sits between the layer top-level start/done control and the MAC datapath.

Parameters:
NUM_TAPS, 15, kernel taps per window; this is also the ring width.
ADDR_W, 4, tap address width; must satisfy 2^ADDR_W > NUM_TAPS.
NUM_WINDOWS, 16, output windows per pass.
WIN_W, 4, window index width; must satisfy 2^WIN_W >= NUM_WINDOWS.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  pass request; sampled only in IDLE.
mac_ready  in  1  MAC can accept a tap this cycle.
out_ready  in  1  downstream accepts the window result.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of pass.
acc_clear  out  1  clears the MAC accumulator.
mac_en  out  1  MAC accumulates the current tap this cycle.
ring_out  out  NUM_TAPS  one-hot tap ring; registered.
tap_addr  out  ADDR_W  binary tap address; combinational from ring_out.
window_idx  out  WIN_W  current window index; registered.
out_valid  out  1  window result available.

Behaviour:
- Reset is synchronous, active-high on clk; one clock, no CDC. On rst the state is IDLE, ring_out = 1 at bit NUM_TAPS-1 (all other bits 0), window_idx=0, and busy, done, acc_clear, mac_en, out_valid are all 0.
- rst asserted mid-pass aborts the pass. All reset values apply at the next edge. No done pulse is produced.
- Ring encoding: bit NUM_TAPS-1 maps to tap_addr 0, and bit i maps to i+1 for i < NUM_TAPS-1. Any non-one-hot ring value gives tap_addr = all ones.
- Ring step: rotate left; bit NUM_TAPS-1 wraps into bit 0. The tap address sequence is therefore 0,1,...,NUM_TAPS-1, then back to 0.
- States: IDLE, CLEAR, RUN, OUTPUT, DONE.
- IDLE: when start=1, go to CLEAR next cycle. In all other states start is ignored.
- CLEAR: lasts one cycle. acc_clear=1. The ring is forced to its reset value. Next state is RUN.
- RUN: mac_en = mac_ready, driven combinationally from state and mac_ready.
  - When mac_ready=1, the ring steps.
  - When mac_ready=0, the ring holds and mac_en=0 (stall). No tap is skipped or repeated.
  - After the cycle with mac_en=1 at tap_addr = NUM_TAPS-1, the ring wraps to tap 0 and the next state is OUTPUT.
  - Exactly NUM_TAPS mac_en pulses occur per window.
- OUTPUT: out_valid=1 and is held until out_ready=1.
  - On the handshake cycle, if window_idx = NUM_WINDOWS-1, go to DONE. Otherwise increment window_idx and go to CLEAR.
  - out_valid rises one cycle after the last mac_en, which gives the MAC one cycle of accumulate latency.
- DONE: lasts one cycle. done=1. window_idx resets to 0. Next state is IDLE. A start seen in this same cycle is ignored.
- Latency for an unstalled window with out_ready held high: 1 (CLEAR) + NUM_TAPS (RUN) + 1 (OUTPUT) = 17 cycles at defaults.
- Latency for an unstalled pass: 17 × NUM_WINDOWS + 1 (DONE) cycles after the cycle in which start is sampled.

Optional Feature:
Macro: TAP_RING_CHECK_EN.
- With the macro defined: add output ring_err (1 bit, reset 0). ring_err is sticky and sets on the first cycle that ring_out is not one-hot. Once set, the FSM forces state to IDLE and stops issuing mac_en. Only rst clears ring_err.
- Without the macro: the port and the check logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds the state enum (IDLE, CLEAR, RUN, OUTPUT, DONE), the ring reset constant, and the default NUM_TAPS/ADDR_W/NUM_WINDOWS/WIN_W constants.
- One sub-module: tap_ring_encoder. It is combinational, maps NUM_TAPS one-hot to ADDR_W binary using the mapping above, and gives all ones on invalid input. It is instantiated once for tap_addr; the optional one-hot check reuses its invalid output.

Test Plan:
- rst for 2 cycles, then idle 5 cycles → ring_out=15'h4000, tap_addr=0, and all control outputs 0 throughout.
- start pulse, mac_ready=1, out_ready=1 → per window, 1 acc_clear, then 15 mac_en with tap_addr 0..14 in order, out_valid on the 17th cycle. window_idx runs 0..15, then a single done pulse 273 cycles after start is sampled.
- mac_ready low for 3 cycles at tap_addr=7 → tap_addr holds at 7, mac_en=0 during the stall, and the sequence resumes at 7 with exactly 15 pulses total.
- out_ready held low 4 cycles in OUTPUT → out_valid stays high and window_idx is unchanged; the handshake cycle then advances to CLEAR with window_idx+1.
- rst asserted at window 5, tap 9 → all outputs at reset values next cycle, no done pulse. A new start restarts at window 0, tap 0.
- With TAP_RING_CHECK_EN, force ring_out=15'h0003 → ring_err=1 next cycle, FSM in IDLE, mac_en stays 0 until rst.
